// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the stall/flush controller.
// The master drives requests and the slave (pipe_ctrl) drives hold/redirect.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int CNT_W  = 16
);
  logic [NSTAGE-1:0] stall_req;
  logic              excp_req;
  logic              eret_req;
  logic [31:0]       epc_i;
  logic              clr_cnt;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic [CNT_W-1:0]  stall_cycles;
  logic              stall_timeout;

  modport master (
    output stall_req, excp_req, eret_req, epc_i, clr_cnt,
    input  stall, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stall_req, excp_req, eret_req, epc_i, clr_cnt,
    output stall, flush, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: upstream stall propagation, exception/eret
// redirect with a one-cycle flush, and stall statistics with a watchdog.
module pipe_ctrl #(
  parameter int          NSTAGE     = 6,
  parameter int          CNT_W      = 16,
  parameter int          WDOG       = 1024,
  parameter logic [31:0] HANDLER_PC = 32'h0000_0020
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WDOG_C  = CNT_W'(WDOG);

  state_t            state_q, state_d;
  logic              flush_q, flush_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  run_q, run_d, run_next;
  logic              timeout_q, timeout_d;
  logic              req_stall;
  logic [NSTAGE-1:0] stall_therm;

  // A stalled stage must also hold every stage upstream of it.
  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_therm
      assign stall_therm[gi] = |bus.stall_req[NSTAGE-1:gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    flush_d   = 1'b0;
    new_pc_d  = new_pc_q;
    bus.stall = '0;
    req_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.excp_req || bus.eret_req) begin
          bus.stall = '1;
          state_d   = FLUSH;
          flush_d   = 1'b1;
          new_pc_d  = bus.excp_req ? HANDLER_PC : bus.epc_i;
        end else begin
          bus.stall = stall_therm;
          req_stall = stall_therm[0];
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      bus.stall = '0;
      req_stall = 1'b0;
    end
  end

  always_comb begin
    run_next = '0;
    if (req_stall) begin
      run_next = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);
    end
    cycles_d  = cycles_q;
    run_d     = run_next;
    timeout_d = timeout_q | (run_next >= WDOG_C);
    if (req_stall && cycles_q != CNT_MAX) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
    // Clearing wins over any same-cycle count or flag set.
    if (bus.clr_cnt) begin
      cycles_d  = '0;
      run_d     = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      flush_q   <= 1'b0;
      new_pc_q  <= '0;
      cycles_q  <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      cycles_q  <= cycles_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_cycles  = cycles_q;
  assign bus.stall_timeout = timeout_q;
endmodule
